// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one pipelined FP-add core between two channels, with flush/idle tracking.
// Latency accept->rsp LAT+2 cycles, 1 op/cycle; requests stall via ready, responses cannot be stalled.
`timescale 1ns/1ps
module fp_add_arbiter #(
  parameter int DW  = 32,
  parameter int LAT = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_result,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_result,
  input  logic          flush,
  output logic          flush_done,
  output logic          idle,
  output logic          add_en,
  output logic [DW-1:0] add_a,
  output logic [DW-1:0] add_b,
  input  logic [DW-1:0] add_result
);

  localparam int CW = $clog2(LAT + 3);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          last_gnt;
  logic          can_acc, gnt0, gnt1, acc, rsp_fire;
  logic [LAT:0]  tag_vld;
  logic [LAT:0]  tag_ch;

  assign can_acc = (state != S_DRAIN) && !flush;

  // last_gnt=1 means ch1 won last, so ch0 wins the next tie
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (can_acc) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_gnt;
        gnt1 = !last_gnt;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign acc        = gnt0 || gnt1;
  assign rsp_fire   = rsp0_valid || rsp1_valid;

  always_comb begin
    count_nxt = count;
    case ({acc, rsp_fire})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (flush)    state_nxt = S_DRAIN;
        else if (acc) state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (flush)                 state_nxt = S_DRAIN;
        else if (count_nxt == '0)  state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (count == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign flush_done = (state == S_DRAIN) && (count == '0);
  assign idle       = (state == S_IDLE) && (count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      count    <= '0;
      last_gnt <= 1'b1;
      tag_vld  <= '0;
      tag_ch   <= '0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      tag_vld <= {tag_vld[LAT-1:0], acc};
      tag_ch  <= {tag_ch[LAT-1:0], gnt1};
      if (acc) last_gnt <= gnt1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      add_en <= 1'b0;
      add_a  <= '0;
      add_b  <= '0;
    end else begin
      add_en <= acc;
      if (acc) begin
        add_a <= gnt1 ? req1_a : req0_a;
        add_b <= gnt1 ? req1_b : req0_b;
      end
    end
  end

  // The last tag stage lines up with the IP output for the op it describes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp1_result <= '0;
    end else begin
      rsp0_valid <= tag_vld[LAT] && !tag_ch[LAT];
      rsp1_valid <= tag_vld[LAT] && tag_ch[LAT];
      if (tag_vld[LAT] && !tag_ch[LAT]) rsp0_result <= add_result;
      if (tag_vld[LAT] && tag_ch[LAT])  rsp1_result <= add_result;
    end
  end

endmodule
